// File: rtl/pc_source_if.sv
// Bus between the control/ALU side and the PC source unit: candidate addresses,
// commit requests and the resulting PC state.
interface pc_source_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_SRC  = 5,
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned CNT_W  = 16
);
    logic [SEL_W-1:0]        sel;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic                    pc_write;
    logic                    pc_write_cond;
    logic                    cond_true;
    logic                    stall;
    logic [DATA_W-1:0]       pc_next;
    logic [DATA_W-1:0]       pc_out;
    logic [DATA_W-1:0]       prev_pc;
    logic                    commit;
    logic                    pending;
    logic                    sel_err;
    logic [CNT_W-1:0]        commit_cnt;

    modport master (
        output sel, src_data, pc_write, pc_write_cond, cond_true, stall,
        input  pc_next, pc_out, prev_pc, commit, pending, sel_err, commit_cnt
    );

    modport slave (
        input  sel, src_data, pc_write, pc_write_cond, cond_true, stall,
        output pc_next, pc_out, prev_pc, commit, pending, sel_err, commit_cnt
    );
endinterface

// File: rtl/pc_source_unit.sv
// PC-next selector and PC register; commits requested while stalled are held and
// applied when the stall releases, with a newer request taking priority.
module pc_source_unit #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       N_SRC    = 5,
    parameter int unsigned       SEL_W    = 3,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    pc_source_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StPending} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] held_q, held_d;
    logic              commit_q, commit_d;
    logic              sel_err_q, sel_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] pc_next;
    logic              sel_bad;
    logic              req;
    logic              do_commit;
    logic [DATA_W-1:0] commit_val;

    // Out-of-range selectors fall back to source 0.
    always_comb begin
        pc_next = bus.src_data[DATA_W-1:0];
        sel_bad = 1'b1;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                pc_next = bus.src_data[k*DATA_W +: DATA_W];
                sel_bad = 1'b0;
            end
        end
    end

    assign req = bus.pc_write | (bus.pc_write_cond & bus.cond_true);

    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        do_commit  = 1'b0;
        commit_val = pc_next;
        sel_err_d  = sel_err_q | (req & sel_bad);

        unique case (state_q)
            StIdle: begin
                if (req && bus.stall) begin
                    held_d  = pc_next;
                    state_d = StPending;
                end else if (req) begin
                    do_commit = 1'b1;
                end
            end
            StPending: begin
                if (bus.stall) begin
                    if (req) begin
                        held_d = pc_next;
                    end
                end else begin
                    do_commit  = 1'b1;
                    commit_val = req ? pc_next : held_q;
                    held_d     = '0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        pc_d     = pc_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        commit_d = do_commit;
        if (do_commit) begin
            pc_d   = commit_val;
            prev_d = pc_q;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            prev_q    <= RESET_PC;
            held_q    <= '0;
            commit_q  <= 1'b0;
            sel_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            prev_q    <= prev_d;
            held_q    <= held_d;
            commit_q  <= commit_d;
            sel_err_q <= sel_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pc_next    = pc_next;
    assign bus.pc_out     = pc_q;
    assign bus.prev_pc    = prev_q;
    assign bus.commit     = commit_q;
    assign bus.pending    = (state_q == StPending);
    assign bus.sel_err    = sel_err_q;
    assign bus.commit_cnt = cnt_q;

endmodule

// File: tb/tb_pc_source_unit.sv
// Directed bench for pc_source_unit: reset, plain/conditional commits, stall deferral,
// new-request priority on release, out-of-range select and counter wrap.
module tb_pc_source_unit;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_SRC  = 5;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pc_source_if #(.DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    pc_source_unit #(
        .DATA_W  (DATA_W),
        .N_SRC   (N_SRC),
        .SEL_W   (SEL_W),
        .RESET_PC('0),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [DATA_W-1:0] val);
        bus.src_data[k*DATA_W +: DATA_W] = val;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.sel           = '0;
        bus.src_data      = '0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.cond_true     = 1'b0;
        bus.stall         = 1'b0;

        // Reset state, observed before any clock edge
        #2 reset = 1'b0;
        #1;
        check("rst_pc", bus.pc_out, 32'h0);
        check("rst_prev", bus.prev_pc, 32'h0);
        check("rst_pending", 32'(bus.pending), 32'h0);
        check("rst_sel_err", 32'(bus.sel_err), 32'h0);
        check("rst_cnt", 32'(bus.commit_cnt), 32'h0);
        check("rst_commit", 32'(bus.commit), 32'h0);
        tick();
        tick();
        reset = 1'b1;

        // Unconditional commit from source 1
        set_src(1, 32'h40);
        bus.sel      = 3'd1;
        bus.pc_write = 1'b1;
        #1;
        check("pc_next_src1", bus.pc_next, 32'h40);
        tick();
        bus.pc_write = 1'b0;
        check("w_pc", bus.pc_out, 32'h40);
        check("w_prev", bus.prev_pc, 32'h0);
        check("w_commit", 32'(bus.commit), 32'h1);
        check("w_cnt", 32'(bus.commit_cnt), 32'h1);
        tick();
        check("w_commit_drop", 32'(bus.commit), 32'h0);
        check("w_pc_hold", bus.pc_out, 32'h40);

        // Conditional commit: false then true
        set_src(2, 32'h100);
        bus.sel           = 3'd2;
        bus.pc_write_cond = 1'b1;
        bus.cond_true     = 1'b0;
        tick();
        check("cf_pc", bus.pc_out, 32'h40);
        check("cf_commit", 32'(bus.commit), 32'h0);
        check("cf_cnt", 32'(bus.commit_cnt), 32'h1);
        bus.cond_true = 1'b1;
        tick();
        bus.pc_write_cond = 1'b0;
        bus.cond_true     = 1'b0;
        check("ct_pc", bus.pc_out, 32'h100);
        check("ct_prev", bus.prev_pc, 32'h40);
        check("ct_commit", 32'(bus.commit), 32'h1);
        check("ct_cnt", 32'(bus.commit_cnt), 32'h2);

        // Stall: two requests, latest wins, applied on release without a request
        bus.stall    = 1'b1;
        set_src(1, 32'h200);
        bus.sel      = 3'd1;
        bus.pc_write = 1'b1;
        tick();
        check("st1_pending", 32'(bus.pending), 32'h1);
        check("st1_pc", bus.pc_out, 32'h100);
        check("st1_commit", 32'(bus.commit), 32'h0);
        set_src(2, 32'h300);
        bus.sel = 3'd2;
        tick();
        check("st2_pending", 32'(bus.pending), 32'h1);
        check("st2_pc", bus.pc_out, 32'h100);
        bus.pc_write = 1'b0;
        tick();
        check("st3_pending", 32'(bus.pending), 32'h1);
        check("st3_pc", bus.pc_out, 32'h100);
        bus.stall = 1'b0;
        tick();
        check("rel_pc", bus.pc_out, 32'h300);
        check("rel_pending", 32'(bus.pending), 32'h0);
        check("rel_commit", 32'(bus.commit), 32'h1);
        check("rel_prev", bus.prev_pc, 32'h100);
        check("rel_cnt", 32'(bus.commit_cnt), 32'h3);

        // Held 0x200 overridden by a request arriving on the release cycle
        bus.stall    = 1'b1;
        set_src(1, 32'h200);
        bus.sel      = 3'd1;
        bus.pc_write = 1'b1;
        tick();
        check("ov_pending", 32'(bus.pending), 32'h1);
        bus.stall = 1'b0;
        set_src(3, 32'h400);
        bus.sel   = 3'd3;
        tick();
        bus.pc_write = 1'b0;
        check("ov_pc", bus.pc_out, 32'h400);
        check("ov_prev", bus.prev_pc, 32'h300);
        check("ov_commit", 32'(bus.commit), 32'h1);
        check("ov_pending_clr", 32'(bus.pending), 32'h0);
        check("ov_cnt", 32'(bus.commit_cnt), 32'h4);
        tick();
        check("ov_pc_hold", bus.pc_out, 32'h400);
        check("ov_commit_once", 32'(bus.commit), 32'h0);

        // Out-of-range selector
        set_src(0, 32'h4);
        bus.sel = 3'd7;
        tick();
        check("bad_noreq_err", 32'(bus.sel_err), 32'h0);
        check("pc_next_fallback", bus.pc_next, 32'h4);
        bus.pc_write = 1'b1;
        tick();
        bus.pc_write = 1'b0;
        check("bad_pc", bus.pc_out, 32'h4);
        check("bad_err", 32'(bus.sel_err), 32'h1);
        check("bad_cnt", 32'(bus.commit_cnt), 32'h5);
        tick();
        check("bad_err_sticky", 32'(bus.sel_err), 32'h1);

        // 12 more commits: 17 total wraps a 4-bit counter to 1
        bus.sel      = 3'd1;
        bus.pc_write = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_src(1, 32'h1000 + 32'(i * 4));
            tick();
        end
        check("wrap_cnt", 32'(bus.commit_cnt), 32'h1);
        check("wrap_pc", bus.pc_out, 32'h102C);
        check("wrap_err_sticky", 32'(bus.sel_err), 32'h1);

        // Same-value commit still pulses and counts
        tick();
        bus.pc_write = 1'b0;
        check("same_pc", bus.pc_out, 32'h102C);
        check("same_prev", bus.prev_pc, 32'h102C);
        check("same_commit", 32'(bus.commit), 32'h1);
        check("same_cnt", 32'(bus.commit_cnt), 32'h2);

        // Reset mid-stall discards the pending commit
        bus.stall    = 1'b1;
        set_src(1, 32'h500);
        bus.pc_write = 1'b1;
        tick();
        bus.pc_write = 1'b0;
        check("ms_pending", 32'(bus.pending), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("ms_rst_pc", bus.pc_out, 32'h0);
        check("ms_rst_prev", bus.prev_pc, 32'h0);
        check("ms_rst_pending", 32'(bus.pending), 32'h0);
        check("ms_rst_err", 32'(bus.sel_err), 32'h0);
        check("ms_rst_cnt", 32'(bus.commit_cnt), 32'h0);
        #1;
        reset     = 1'b1;
        bus.stall = 1'b0;
        tick();
        check("ms_after_pc", bus.pc_out, 32'h0);
        check("ms_after_commit", 32'(bus.commit), 32'h0);
        check("ms_after_pending", 32'(bus.pending), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
